// File: rtl/exec_sequencer_if.sv
// Decoder/ALU/write-back signal bundle for the execute sequencer.
// master = decoder, ALU and register-file side; slave = sequencer.
interface exec_sequencer_if;
  logic       id_valid;
  logic       id_ready;
  logic [1:0] id_type;
  logic [4:0] id_alu_op;
  logic [1:0] id_dst;
  logic [7:0] id_data;
  logic       flush;
  logic       alu_en;
  logic [4:0] alu_op;
  logic [7:0] alu_ans;
  logic [7:0] alu_ans_hi;
  logic [7:0] alu_psw;
  logic       acc_we;
  logic       b_we;
  logic       psw_we;
  logic [7:0] wb_acc;
  logic [7:0] wb_b;
  logic [7:0] wb_psw;
  logic       busy;

  modport master (
    output id_valid, id_type, id_alu_op, id_dst, id_data, flush,
    output alu_ans, alu_ans_hi, alu_psw,
    input  id_ready, alu_en, alu_op, acc_we, b_we, psw_we,
    input  wb_acc, wb_b, wb_psw, busy
  );

  modport slave (
    input  id_valid, id_type, id_alu_op, id_dst, id_data, flush,
    input  alu_ans, alu_ans_hi, alu_psw,
    output id_ready, alu_en, alu_op, acc_we, b_we, psw_we,
    output wb_acc, wb_b, wb_psw, busy
  );
endinterface

// File: rtl/exec_sequencer.sv
// 8051 execute-stage sequencer: one instruction in flight, ALU ops 1 or MULDIV_CYCLES
// execute cycles then a one-cycle write-back; id_ready only in IDLE with no flush.
module exec_sequencer #(
  parameter int         MULDIV_CYCLES = 4,
  parameter logic [4:0] OP_MUL        = 5'h0C,
  parameter logic [4:0] OP_DIV        = 5'h0D
) (
  input  logic              clk,
  input  logic              rst_n,
  exec_sequencer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  localparam logic [1:0] T_ALU = 2'b01;
  localparam logic [1:0] T_MOV = 2'b10;

  localparam logic [1:0] D_ACC = 2'b00;
  localparam logic [1:0] D_B   = 2'b01;
  localparam logic [1:0] D_AB  = 2'b10;

  localparam logic [3:0] CNT_MULDIV = 4'(MULDIV_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] dst_q;
  logic [3:0] cnt;
  logic       accept;
  logic       is_muldiv;

  assign bus.id_ready = (state == ST_IDLE) && !bus.flush;
  assign bus.busy     = (state != ST_IDLE);
  assign accept       = bus.id_valid && bus.id_ready;
  assign is_muldiv    = (bus.id_alu_op == OP_MUL) || (bus.id_alu_op == OP_DIV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      dst_q      <= 2'b00;
      cnt        <= 4'd0;
      bus.alu_en <= 1'b0;
      bus.alu_op <= 5'd0;
      bus.acc_we <= 1'b0;
      bus.b_we   <= 1'b0;
      bus.psw_we <= 1'b0;
      bus.wb_acc <= 8'd0;
      bus.wb_b   <= 8'd0;
      bus.wb_psw <= 8'd0;
    end else begin
      // Strobes are single-cycle pulses; only the entry into WB raises them.
      bus.acc_we <= 1'b0;
      bus.b_we   <= 1'b0;
      bus.psw_we <= 1'b0;

      if (bus.flush) begin
        state      <= ST_IDLE;
        cnt        <= 4'd0;
        bus.alu_en <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              dst_q      <= bus.id_dst;
              bus.alu_op <= bus.id_alu_op;
              case (bus.id_type)
                T_ALU: begin
                  state      <= ST_EXEC;
                  bus.alu_en <= 1'b1;
                  cnt        <= is_muldiv ? CNT_MULDIV : 4'd0;
                end
                T_MOV: begin
                  state      <= ST_WB;
                  bus.acc_we <= (bus.id_dst == D_ACC);
                  bus.b_we   <= (bus.id_dst == D_B);
                  if (bus.id_dst == D_ACC) bus.wb_acc <= bus.id_data;
                  if (bus.id_dst == D_B)   bus.wb_b   <= bus.id_data;
                end
                default: state <= ST_WB;
              endcase
            end
          end

          ST_EXEC: begin
            if (cnt == 4'd0) begin
              state      <= ST_WB;
              bus.alu_en <= 1'b0;
              bus.wb_acc <= bus.alu_ans;
              // A single-register B destination takes the low result byte.
              bus.wb_b   <= (dst_q == D_B) ? bus.alu_ans : bus.alu_ans_hi;
              bus.wb_psw <= bus.alu_psw;
              bus.psw_we <= 1'b1;
              bus.acc_we <= (dst_q == D_ACC) || (dst_q == D_AB);
              bus.b_we   <= (dst_q == D_B) || (dst_q == D_AB);
            end else begin
              cnt <= cnt - 4'd1;
            end
          end

          ST_WB:   state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed and randomized bench for exec_sequencer against a per-instruction reference model.
module tb_exec_sequencer;
  localparam int         M      = 4;
  localparam logic [4:0] OP_MUL = 5'h0C;
  localparam logic [4:0] OP_DIV = 5'h0D;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exec_sequencer_if bus ();

  exec_sequencer #(
    .MULDIV_CYCLES (M),
    .OP_MUL        (OP_MUL),
    .OP_DIV        (OP_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_alu();
    bus.alu_ans    = 8'($urandom);
    bus.alu_ans_hi = 8'($urandom);
    bus.alu_psw    = 8'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"},  32'(bus.id_ready), 32'(1));
    check({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check({tag, "_en"},   32'(bus.alu_en), 32'(0));
    check({tag, "_we"},   32'({bus.acc_we, bus.b_we, bus.psw_we}), 32'(0));
  endtask

  // Issues one instruction and checks its whole life, EXEC length and write-back
  // derived from the instruction rules. Caller is at a negedge; returns at a negedge.
  task automatic run_instr(input logic [1:0] t, input logic [4:0] op,
                           input logic [1:0] dst, input logic [7:0] d);
    int         n;
    int         guard;
    logic [7:0] ans, hi, psw;
    logic       ea, eb, ep;
    logic [7:0] va, vb;
    guard = 0;
    ans = 8'd0; hi = 8'd0; psw = 8'd0;
    while (!bus.id_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("ready_timeout", 32'(bus.id_ready), 32'(1));
    bus.id_valid  = 1'b1;
    bus.id_type   = t;
    bus.id_alu_op = op;
    bus.id_dst    = dst;
    bus.id_data   = d;
    drive_alu();
    @(posedge clk);
    #1 bus.id_valid = 1'b0;

    if (t == 2'b01) n = (op == OP_MUL || op == OP_DIV) ? M : 1;
    else            n = 0;

    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check("exec_en",   32'(bus.alu_en), 32'(1));
      check("exec_op",   32'(bus.alu_op), 32'(op));
      check("exec_we",   32'({bus.acc_we, bus.b_we, bus.psw_we}), 32'(0));
      check("exec_busy", 32'(bus.busy), 32'(1));
      check("exec_rdy",  32'(bus.id_ready), 32'(0));
      drive_alu();
      if (k == n) begin
        ans = bus.alu_ans; hi = bus.alu_ans_hi; psw = bus.alu_psw;
      end
    end

    ea = 1'b0; eb = 1'b0; ep = 1'b0; va = 8'd0; vb = 8'd0;
    if (t == 2'b01) begin
      ep = 1'b1;
      ea = (dst == 2'b00) || (dst == 2'b10);
      eb = (dst == 2'b01) || (dst == 2'b10);
      va = ans;
      vb = (dst == 2'b10) ? hi : ans;
    end else if (t == 2'b10) begin
      ea = (dst == 2'b00);
      eb = (dst == 2'b01);
      va = d;
      vb = d;
    end

    @(negedge clk);
    check("wb_en",     32'(bus.alu_en), 32'(0));
    check("wb_busy",   32'(bus.busy), 32'(1));
    check("wb_acc_we", 32'(bus.acc_we), 32'(ea));
    check("wb_b_we",   32'(bus.b_we), 32'(eb));
    check("wb_psw_we", 32'(bus.psw_we), 32'(ep));
    if (ea) check("wb_acc", 32'(bus.wb_acc), 32'(va));
    if (eb) check("wb_b",   32'(bus.wb_b), 32'(vb));
    if (ep) check("wb_psw", 32'(bus.wb_psw), 32'(psw));

    @(negedge clk);
    check_idle("post");
  endtask

  initial begin
    bus.id_valid   = 1'b0;
    bus.id_type    = 2'b00;
    bus.id_alu_op  = 5'd0;
    bus.id_dst     = 2'b00;
    bus.id_data    = 8'd0;
    bus.flush      = 1'b0;
    bus.alu_ans    = 8'd0;
    bus.alu_ans_hi = 8'd0;
    bus.alu_psw    = 8'd0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_en",   32'(bus.alu_en), 32'(0));
    check("rst_op",   32'(bus.alu_op), 32'(0));
    check("rst_we",   32'({bus.acc_we, bus.b_we, bus.psw_we}), 32'(0));
    check("rst_data", 32'({bus.wb_acc, bus.wb_b, bus.wb_psw}), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rel");

    // ADD to ACC
    bus.alu_psw = 8'h80;
    run_instr(2'b01, 5'h01, 2'b00, 8'h00);

    // MUL AB into ACC+B
    run_instr(2'b01, OP_MUL, 2'b10, 8'h00);

    // MOV B then back-to-back NOP
    run_instr(2'b10, 5'h00, 2'b01, 8'h3C);
    run_instr(2'b00, 5'h00, 2'b11, 8'h00);

    // DIV to B only still takes the long execute
    run_instr(2'b01, OP_DIV, 2'b01, 8'h00);

    // Flush in DIV EXEC cycle 3 with a MOV waiting
    bus.id_valid = 1'b1; bus.id_type = 2'b01; bus.id_alu_op = OP_DIV; bus.id_dst = 2'b10;
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("fl_pre_en", 32'(bus.alu_en), 32'(1));
    bus.flush = 1'b1;
    bus.id_valid = 1'b1; bus.id_type = 2'b10; bus.id_dst = 2'b00; bus.id_data = 8'hA5;
    #1;
    check("fl_rdy", 32'(bus.id_ready), 32'(0));
    check("fl_we",  32'({bus.acc_we, bus.b_we, bus.psw_we}), 32'(0));
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check_idle("fl_after");
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    @(negedge clk);
    check("fl_mov_acc_we", 32'(bus.acc_we), 32'(1));
    check("fl_mov_acc",    32'(bus.wb_acc), 32'(8'hA5));
    check("fl_mov_b_we",   32'(bus.b_we), 32'(0));
    check("fl_mov_psw_we", 32'(bus.psw_we), 32'(0));
    @(negedge clk);
    check_idle("fl_done");

    // Reset during MUL EXEC cycle 2
    bus.id_valid = 1'b1; bus.id_type = 2'b01; bus.id_alu_op = OP_MUL; bus.id_dst = 2'b10;
    @(posedge clk);
    #1 bus.id_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_en",   32'(bus.alu_en), 32'(0));
    check("mr_op",   32'(bus.alu_op), 32'(0));
    check("mr_we",   32'({bus.acc_we, bus.b_we, bus.psw_we}), 32'(0));
    check("mr_data", 32'({bus.wb_acc, bus.wb_b, bus.wb_psw}), 32'(0));
    check("mr_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_idle("mr_idle");
    end

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      logic [1:0] t;
      logic [4:0] op;
      t = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) op = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV;
      else                           op = 5'($urandom_range(0, 31));
      run_instr(t, op, 2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
